// File: rtl/delay_timer_bank_if.sv
// -----------------------------------------------------------------------------
// delay_timer_bank_if
// Control/status bundle for the delay_timer_bank timer array.
//   en        : global count enable (0 pauses every channel)
//   start     : per-channel start/restart request
//   stop      : per-channel abort (wins over start)
//   periodic  : per-channel mode, latched at start (1 = periodic)
//   limit     : channel i terminal count in [i*CBITS +: CBITS], latched at start
//   err_clr   : per-channel clear of the sticky overrun flag
//   sig       : one-cycle expiry pulse per channel
//   busy      : channel is running
//   flg       : busy and not pulsing this cycle
//   err       : sticky one-shot overrun flag
//   any_sig   : OR of sig, aligned with sig
// master drives the controls, slave is the timer bank.
// -----------------------------------------------------------------------------
interface delay_timer_bank_if #(
   parameter int NCH   = 4,
   parameter int CBITS = 15
);
   logic                   en;
   logic [NCH-1:0]         start;
   logic [NCH-1:0]         stop;
   logic [NCH-1:0]         periodic;
   logic [NCH*CBITS-1:0]   limit;
   logic [NCH-1:0]         err_clr;
   logic [NCH-1:0]         sig;
   logic [NCH-1:0]         busy;
   logic [NCH-1:0]         flg;
   logic [NCH-1:0]         err;
   logic                   any_sig;

   modport master (
      output en, start, stop, periodic, limit, err_clr,
      input  sig, busy, flg, err, any_sig
   );

   modport slave (
      input  en, start, stop, periodic, limit, err_clr,
      output sig, busy, flg, err, any_sig
   );
endinterface

// File: rtl/delay_timer_bank.sv
// -----------------------------------------------------------------------------
// delay_timer_bank
// NCH independent delay/period timers. Each channel latches a terminal count
// and a mode on start, counts up while en is high and emits a one-cycle sig
// pulse when the count reaches the latched limit (latency limit+1 cycles).
// One-shot channels return to idle on expiry; periodic channels reload.
// A start arriving while a one-shot channel is still running sets a sticky err.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset
//   bus : delay_timer_bank_if.slave control/status bundle
// All outputs are registered.
// -----------------------------------------------------------------------------
module delay_timer_bank #(
   parameter int NCH           = 4,
   parameter int CBITS         = 15,
   parameter int DEFAULT_LIMIT = 22500
) (
   input  logic                clk,
   input  logic                rst,
   delay_timer_bank_if.slave   bus
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   // A limit field of all ones selects the built-in default limit.
   localparam logic [CBITS-1:0] DEF_LIMIT = CBITS'(DEFAULT_LIMIT);

   state_t           state_r [NCH];
   state_t           state_s [NCH];
   logic [CBITS-1:0] cnt_r   [NCH];
   logic [CBITS-1:0] cnt_s   [NCH];
   logic [CBITS-1:0] lim_r   [NCH];
   logic [CBITS-1:0] lim_s   [NCH];
   logic [NCH-1:0]   mode_r;
   logic [NCH-1:0]   mode_s;
   logic [NCH-1:0]   sig_r;
   logic [NCH-1:0]   sig_s;
   logic [NCH-1:0]   busy_r;
   logic [NCH-1:0]   busy_s;
   logic [NCH-1:0]   flg_r;
   logic [NCH-1:0]   flg_s;
   logic [NCH-1:0]   err_r;
   logic [NCH-1:0]   err_s;
   logic [NCH-1:0]   err_set_s;
   logic             any_sig_r;
   logic             any_sig_s;

   // Per-channel next-state, counter and output decode.
   always_comb begin
      for (int i = 0; i < NCH; i++) begin
         state_s[i]   = state_r[i];
         cnt_s[i]     = cnt_r[i];
         lim_s[i]     = lim_r[i];
         mode_s[i]    = mode_r[i];
         sig_s[i]     = 1'b0;
         err_set_s[i] = 1'b0;

         if (bus.stop[i]) begin
            // Abort has priority over a simultaneous start.
            state_s[i] = IDLE;
            cnt_s[i]   = '0;
         end else if (bus.start[i]) begin
            // Restart also overrides an expiry in the same cycle (no pulse).
            err_set_s[i] = (state_r[i] == RUN) && !mode_r[i];
            state_s[i]   = RUN;
            cnt_s[i]     = '0;
            mode_s[i]    = bus.periodic[i];
            if (bus.limit[i*CBITS +: CBITS] == {CBITS{1'b1}}) begin
               lim_s[i] = DEF_LIMIT;
            end else begin
               lim_s[i] = bus.limit[i*CBITS +: CBITS];
            end
         end else begin
            case (state_r[i])
               IDLE: begin
                  cnt_s[i] = '0;
               end
               RUN: begin
                  if (bus.en) begin
                     if (cnt_r[i] == lim_r[i]) begin
                        sig_s[i]   = 1'b1;
                        cnt_s[i]   = '0;
                        state_s[i] = mode_r[i] ? RUN : IDLE;
                     end else begin
                        cnt_s[i] = cnt_r[i] + CBITS'(1);
                     end
                  end else begin
                     cnt_s[i] = cnt_r[i];
                  end
               end
               default: begin
                  state_s[i] = IDLE;
                  cnt_s[i]   = '0;
               end
            endcase
         end

         // A new overrun wins over a clear in the same cycle.
         err_s[i]  = err_set_s[i] | (err_r[i] & ~bus.err_clr[i]);
         busy_s[i] = (state_s[i] == RUN);
         flg_s[i]  = busy_s[i] & ~sig_s[i];
      end
      any_sig_s = |sig_s;
   end

   // State, counters, latched configuration and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            state_r[i] <= IDLE;
            cnt_r[i]   <= '0;
            lim_r[i]   <= '0;
         end
         mode_r    <= '0;
         sig_r     <= '0;
         busy_r    <= '0;
         flg_r     <= '0;
         err_r     <= '0;
         any_sig_r <= 1'b0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            state_r[i] <= state_s[i];
            cnt_r[i]   <= cnt_s[i];
            lim_r[i]   <= lim_s[i];
         end
         mode_r    <= mode_s;
         sig_r     <= sig_s;
         busy_r    <= busy_s;
         flg_r     <= flg_s;
         err_r     <= err_s;
         any_sig_r <= any_sig_s;
      end
   end

   assign bus.sig     = sig_r;
   assign bus.busy    = busy_r;
   assign bus.flg     = flg_r;
   assign bus.err     = err_r;
   assign bus.any_sig = any_sig_r;

endmodule

// File: tb/tb_delay_timer_bank.sv
// -----------------------------------------------------------------------------
// tb_delay_timer_bank
// Directed scenarios followed by random traffic. A countdown reference model
// (remaining cycles until expiry per channel) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_delay_timer_bank;
   localparam int NCH   = 4;
   localparam int CBITS = 15;
   localparam int DEFL  = 22500;
   localparam int ONES  = (1 << CBITS) - 1;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   delay_timer_bank_if #(.NCH(NCH), .CBITS(CBITS)) bus ();

   delay_timer_bank #(.NCH(NCH), .CBITS(CBITS), .DEFAULT_LIMIT(DEFL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // reference model state
   logic           m_run  [NCH];
   int             m_rem  [NCH];
   int             m_lim  [NCH];
   logic           m_mode [NCH];
   logic           m_err  [NCH];
   logic [NCH-1:0] m_sig;

   task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_run[i] = 1'b0; m_rem[i] = 0; m_lim[i] = 0; m_mode[i] = 1'b0; m_err[i] = 1'b0;
         end
         m_sig = '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            int   f;
            logic set;
            set = 1'b0;
            m_sig[i] = 1'b0;
            f = int'(bus.limit[i*CBITS +: CBITS]);
            if (bus.stop[i]) begin
               m_run[i] = 1'b0;
            end else if (bus.start[i]) begin
               if (m_run[i] && !m_mode[i]) set = 1'b1;
               m_run[i]  = 1'b1;
               m_lim[i]  = (f == ONES) ? DEFL : f;
               m_rem[i]  = m_lim[i];
               m_mode[i] = bus.periodic[i];
            end else if (m_run[i] && bus.en) begin
               if (m_rem[i] == 0) begin
                  m_sig[i] = 1'b1;
                  m_rem[i] = m_lim[i];
                  if (!m_mode[i]) m_run[i] = 1'b0;
               end else begin
                  m_rem[i] = m_rem[i] - 1;
               end
            end
            m_err[i] = set | (m_err[i] & ~bus.err_clr[i]);
         end
      end
   endtask

   task automatic check_model();
      logic [NCH-1:0] eb, ee;
      for (int i = 0; i < NCH; i++) begin
         eb[i] = m_run[i];
         ee[i] = m_err[i];
      end
      chk("sig",     bus.sig,  m_sig);
      chk("busy",    bus.busy, eb);
      chk("flg",     bus.flg,  eb & ~m_sig);
      chk("err",     bus.err,  ee);
      chk("any_sig", {3'b000, bus.any_sig}, {3'b000, |m_sig});
   endtask

   // One rising edge; inputs stay stable across it and change only after.
   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      check_model();
   endtask

   task automatic set_lim(input int ch, input int v);
      bus.limit[ch*CBITS +: CBITS] = CBITS'(v);
   endtask

   initial begin
      for (int i = 0; i < NCH; i++) begin
         m_run[i] = 1'b0; m_rem[i] = 0; m_lim[i] = 0; m_mode[i] = 1'b0; m_err[i] = 1'b0;
      end
      m_sig = '0;
      rst = 1'b1;
      bus.en = 1'b1; bus.start = 4'hF; bus.stop = 4'h0; bus.periodic = 4'h0;
      bus.limit = '0; bus.err_clr = 4'h0;

      // reset with start asserted
      step(); step();
      chk("rst_sig", bus.sig, 4'h0);
      chk("rst_busy", bus.busy, 4'h0);
      rst = 1'b0; bus.start = 4'h0;
      step();
      chk("post_rst_busy", bus.busy, 4'h0);
      chk("post_rst_err", bus.err, 4'h0);

      // one-shot ch0, limit 3
      set_lim(0, 3); bus.periodic[0] = 1'b0; bus.start[0] = 1'b1;
      step();
      bus.start[0] = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("os_sig0",  {3'b000, bus.sig[0]},  {3'b000, k == 4});
         chk("os_busy0", {3'b000, bus.busy[0]}, {3'b000, k < 4});
         chk("os_err0",  {3'b000, bus.err[0]},  4'h0);
      end

      // periodic ch1, limit 2, en low before edge 6 for two cycles
      set_lim(1, 2); bus.periodic[1] = 1'b1; bus.start[1] = 1'b1;
      step();
      bus.start[1] = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         bus.en = !(k == 6 || k == 7);
         step();
         chk("per_sig1", {3'b000, bus.sig[1]}, {3'b000, (k == 3 || k == 8 || k == 11)});
      end
      bus.en = 1'b1; bus.stop[1] = 1'b1;
      step();
      bus.stop[1] = 1'b0;

      // overrun ch2, limit 10, restart at edge 5
      set_lim(2, 10); bus.periodic[2] = 1'b0; bus.start[2] = 1'b1;
      step();
      for (int k = 1; k <= 17; k++) begin
         bus.start[2] = (k == 5);
         step();
         chk("ovr_err2", {3'b000, bus.err[2]}, {3'b000, k >= 5});
         chk("ovr_sig2", {3'b000, bus.sig[2]}, {3'b000, k == 16});
      end
      bus.start[2] = 1'b1;
      step();
      bus.err_clr[2] = 1'b1;
      step();
      chk("ovr_setwins", {3'b000, bus.err[2]}, 4'h1);
      bus.start[2] = 1'b0;
      step();
      chk("ovr_clr", {3'b000, bus.err[2]}, 4'h0);
      bus.err_clr[2] = 1'b0; bus.stop[2] = 1'b1;
      step();
      bus.stop[2] = 1'b0;

      // default limit expiry on ch3
      set_lim(3, ONES); bus.periodic[3] = 1'b0; bus.start[3] = 1'b1;
      step();
      bus.start[3] = 1'b0;
      for (int k = 1; k <= DEFL + 2; k++) begin
         step();
         if (k >= DEFL) chk("def_sig3", {3'b000, bus.sig[3]}, {3'b000, k == DEFL + 1});
      end

      // stop at cycle 100, then start+stop together
      bus.start[3] = 1'b1;
      step();
      bus.start[3] = 1'b0;
      for (int k = 1; k < 100; k++) step();
      chk("stop_pre_busy3", {3'b000, bus.busy[3]}, 4'h1);
      bus.stop[3] = 1'b1;
      step();
      chk("stop_busy3", {3'b000, bus.busy[3]}, 4'h0);
      bus.stop[3] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stop_sig3", {3'b000, bus.sig[3]}, 4'h0);
      end
      bus.start[3] = 1'b1; bus.stop[3] = 1'b1;
      step();
      chk("startstop_busy3", {3'b000, bus.busy[3]}, 4'h0);
      bus.start[3] = 1'b0; bus.stop[3] = 1'b0;

      // all channels limit 0 periodic
      bus.limit = '0; bus.periodic = 4'hF; bus.start = 4'hF;
      step();
      bus.start = 4'h0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("conc_sig", bus.sig, 4'hF);
         chk("conc_any", {3'b000, bus.any_sig}, 4'h1);
      end
      bus.stop = 4'hF;
      step();
      chk("conc_stop_sig", bus.sig, 4'h0);
      bus.stop = 4'h0;

      // random traffic against the model
      for (int k = 0; k < 800; k++) begin
         rst    = ($urandom_range(0, 299) == 0);
         bus.en = ($urandom_range(0, 7) != 0);
         for (int i = 0; i < NCH; i++) begin
            bus.start[i]    = ($urandom_range(0, 7) == 0);
            bus.stop[i]     = ($urandom_range(0, 19) == 0);
            bus.err_clr[i]  = ($urandom_range(0, 9) == 0);
            bus.periodic[i] = $urandom_range(0, 1);
            set_lim(i, ($urandom_range(0, 9) == 0) ? ONES : int'($urandom_range(0, 6)));
         end
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/delay_timer_bank.md
# delay_timer_bank

Bank of `NCH` independent programmable delay/period timers sharing one clock. Each channel counts to a terminal value latched at start and emits a one-cycle `sig` pulse. The pulse is either one-shot or periodic, selected per channel. Each channel also provides `busy`/`flg` status and a sticky `err` for one-shot overrun. It generalises the fixed-N single-channel delay counter: width, channel count, limit and mode are now configurable, and start/stop/pause control is added. It sits between control FSMs and datapath blocks that need timeouts or periodic ticks.

## Interface
Parameters:
- `NCH`, 4, number of channels
- `CBITS`, 15, counter/limit width
- `DEFAULT_LIMIT`, 22500, limit used when a start sees `limit` field == all-ones (must fit `CBITS`)

Ports:
- `clk` in 1: single clock; all logic on posedge
- `rst` in 1: synchronous, active-high reset
- `en` in 1: global count enable; 0 = all channels pause
- `start` in NCH: per-channel start/restart request
- `stop` in NCH: per-channel abort
- `periodic` in NCH: mode latched at start (1 = periodic, 0 = one-shot)
- `limit` in NCH*CBITS: channel i terminal count in bits [i*CBITS +: CBITS], latched at start
- `err_clr` in NCH: clear sticky error
- `sig` out NCH: registered one-cycle expiry pulse
- `busy` out NCH: channel in RUN
- `flg` out NCH: `busy & ~sig`, registered
- `err` out NCH: sticky one-shot overrun flag
- `any_sig` out 1: registered OR of next `sig` vector (same cycle as `sig`)

## Operation
- Per-channel state: IDLE, RUN; `cnt[CBITS-1:0]`, latched `L`, latched `mode`.
- IDLE: `cnt`=0, outputs `busy`=0, `flg`=0, `sig`=0.
- start (stop low): enter/re-enter RUN, `cnt`<=0, `L`<=`limit` field (all-ones -> `DEFAULT_LIMIT`), `mode`<=`periodic[i]`. Accepted regardless of `en`.
- RUN with `en`=1:
  - `cnt`!=`L`: `cnt`++.
  - `cnt`==`L`: `sig`<=1, `cnt`<=0. Periodic stays in RUN; one-shot goes to IDLE.
- RUN with `en`=0: `cnt` holds, `sig`<=0.
- stop: IDLE, `cnt`<=0, no `sig`. stop+start same cycle -> stop wins.
- `err` set when start arrives while RUN and latched `mode`=0 (one-shot retriggered before expiry). The restart still happens. Periodic restarts never set `err`.
- `err_clr` clears `err`; set and clear in the same cycle -> set wins.
- Arithmetic: equality compare only; `cnt` ≤ `L` ≤ 2^CBITS−1, so there is no wrap. `L`=0 is legal: periodic gives `sig` every cycle.
- Changes to `limit`/`periodic` while RUN are ignored until the next start.

## Timing
- Reset: `sig`, `busy`, `flg`, `err`, `any_sig` = 0; all `cnt`, `L`, `mode` = 0; all channels IDLE.
- Start sampled at edge t0: `busy`=1 after t0. With `en` continuously 1, `sig`=1 for exactly one cycle after edge t0+L+1 (latency L+1).
- Periodic: `sig` period L+1 cycles; every `en`-low cycle adds one cycle.
- One-shot: `busy` falls at the same edge `sig` rises; `flg`=0 during the `sig` cycle.
- Restart on the expiry cycle: start wins, no `sig` is produced, and `cnt`<=0.
- `rst` mid-operation: every channel returns to IDLE at that edge with no `sig`; `err` clears.
- Channels are fully independent; simultaneous expiries give multiple `sig` bits high in the same cycle.

## Test plan
- Reset check: `rst`=1 for 2 cycles with `start`=4'hF -> all outputs 0, no channel busy after release.
- One-shot: ch0 `limit`=3, `periodic`=0, start at edge 0 -> `sig[0]` high only after edge 4; `busy[0]` high edges 0–3, low from 4; `err[0]`=0.
- Periodic + pause: ch1 `limit`=2, periodic, start -> `sig[1]` after edges 3, 6, 9. Drop `en` for 2 cycles before edge 6 -> pulses at 3, 8, 11.
- Overrun: ch2 one-shot `limit`=10, start at 0, start again at 5 -> `err[2]`=1 from edge 5 and stays; `sig[2]` after edge 16. `err_clr[2]` with simultaneous start while busy -> `err` stays 1.
- Stop/default: ch3 start with `limit`=15'h7FFF -> `L`=22500; stop at cycle 100 -> `busy[3]`=0 and no `sig`. Start+stop same cycle -> channel stays IDLE.
- Concurrency: all four channels `limit`=0 periodic -> `sig`=4'hF and `any_sig`=1 every cycle until stopped.
